// File: rtl/timekeeper_pkg.sv
// Shared types, limits and BCD helpers
// for the time-of-day counter.
package timekeeper_pkg;

  localparam logic [3:0] MAX_HH_T = 4'd2;
  localparam logic [7:0] MAX_HH   = 8'h23;
  localparam logic [3:0] MAX_MS_T = 4'd5;

  typedef logic [3:0] bcd_t;

  // Packed {hh,mm,ss} BCD legality check.
  function automatic logic bcd_valid_hms(
    input logic [23:0] t
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    if (t[7:4] > MAX_MS_T)   ok = 1'b0;
    if (t[15:12] > MAX_MS_T) ok = 1'b0;
    if (t[23:20] > MAX_HH_T) ok = 1'b0;
    if (t[23:16] > MAX_HH)   ok = 1'b0;
    return ok;
  endfunction

  // 24h BCD hour -> {pm, 12h BCD hour}.
  function automatic logic [8:0] to_12h(
    input logic [7:0] hh
  );
    logic [8:0] r;
    r = {1'b0, hh};
    if (hh == 8'h00) begin
      r = {1'b0, 8'h12};
    end else if (hh == 8'h12) begin
      r = {1'b1, 8'h12};
    end else if (hh > 8'h12) begin
      if (hh[7:4] == 4'd1)
        r = {1'b1, 4'd0, hh[3:0] - 4'd2};
      else if (hh[3:0] < 4'd2)
        r = {1'b1, 4'd0, hh[3:0] + 4'd8};
      else
        r = {1'b1, 4'd1, hh[3:0] - 4'd2};
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the board clock to a one-cycle
// tick per second; clear restarts the second.
module tick_prescaler #(
  parameter int CLK_FREQ = 1_200_000,
  parameter int CNT_W    = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] TC =
    CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = run & (cnt_q == TC);

  // Next count: clear wins, wrap on terminal.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (tick)
      cnt_d = '0;
    else if (run)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bcd_timekeeper.sv
// 24h BCD time-of-day counter with load,
// alarm and 12h display mapping.
module bcd_timekeeper
  import timekeeper_pkg::*;
#(
  parameter int CLK_FREQ = 1_200_000,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        mode_12h,
  input  logic        set_valid,
  input  logic [23:0] set_time,
  input  logic        alm_valid,
  input  logic [15:0] alm_time,
  input  logic        alm_en,
  output logic        set_err,
  output logic        tick_1hz,
  output logic        alarm_hit,
  output logic        pm,
  output logic [3:0]  sec_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  min_tens,
  output logic [3:0]  hour_ones,
  output logic [3:0]  hour_tens
);

  logic [23:0] time_q, time_d, inc;
  logic [15:0] alm_q, alm_d;
  logic        err_q, err_d;
  logic        tk_q, tk_d;
  logic        hit_q, hit_d;
  logic        tick, set_ok, alm_ok;
  logic        set_ld, adv;
  logic        c0, c1, c2, c3;
  logic [8:0]  h12;

  tick_prescaler #(
    .CLK_FREQ (CLK_FREQ),
    .CNT_W    (CNT_W)
  ) u_pre (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clear (set_ld),
    .tick  (tick)
  );

  assign set_ok = bcd_valid_hms(set_time);
  assign alm_ok = bcd_valid_hms({alm_time, 8'h00});
  assign set_ld = set_valid & set_ok;
  assign adv    = tick & ~set_ld;

  // One-second BCD increment with carry chain.
  always_comb begin
    c0  = time_q[3:0] == 4'd9;
    c1  = c0 & (time_q[7:4] == MAX_MS_T);
    c2  = c1 & (time_q[11:8] == 4'd9);
    c3  = c2 & (time_q[15:12] == MAX_MS_T);
    inc = time_q;
    inc[3:0] = c0 ? 4'd0 : time_q[3:0] + 4'd1;
    if (c1)      inc[7:4] = 4'd0;
    else if (c0) inc[7:4] = time_q[7:4] + 4'd1;
    if (c2)      inc[11:8] = 4'd0;
    else if (c1) inc[11:8] = time_q[11:8] + 4'd1;
    if (c3)      inc[15:12] = 4'd0;
    else if (c2) inc[15:12] = time_q[15:12] + 4'd1;
    if (c3) begin
      if (time_q[23:16] == MAX_HH)
        inc[23:16] = 8'h00;
      else if (time_q[19:16] == 4'd9)
        inc[23:16] = {time_q[23:20] + 4'd1, 4'd0};
      else
        inc[19:16] = time_q[19:16] + 4'd1;
    end
  end

  // Next state: load beats tick, alarm compare.
  always_comb begin
    time_d = time_q;
    if (set_ld)   time_d = set_time;
    else if (adv) time_d = inc;
    alm_d = alm_q;
    if (alm_valid & alm_ok) alm_d = alm_time;
    err_d = (set_valid & ~set_ok) |
            (alm_valid & ~alm_ok);
    tk_d  = adv;
    hit_d = adv & alm_en &
            (inc == {alm_q, 8'h00});
  end

  // State and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q <= '0;
      alm_q  <= '0;
      err_q  <= 1'b0;
      tk_q   <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      time_q <= time_d;
      alm_q  <= alm_d;
      err_q  <= err_d;
      tk_q   <= tk_d;
      hit_q  <= hit_d;
    end
  end

  assign h12       = to_12h(time_q[23:16]);
  assign set_err   = err_q;
  assign tick_1hz  = tk_q;
  assign alarm_hit = hit_q;
  assign pm        = mode_12h & h12[8];
  assign sec_ones  = time_q[3:0];
  assign sec_tens  = time_q[7:4];
  assign min_ones  = time_q[11:8];
  assign min_tens  = time_q[15:12];
  assign hour_ones = mode_12h ? h12[3:0]
                              : time_q[19:16];
  assign hour_tens = mode_12h ? h12[7:4]
                              : time_q[23:20];

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Directed checks for bcd_timekeeper
// with a four-cycle second.
module tb_bcd_timekeeper;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        mode_12h = 1'b0;
  logic        set_valid = 1'b0;
  logic [23:0] set_time = '0;
  logic        alm_valid = 1'b0;
  logic [15:0] alm_time = '0;
  logic        alm_en = 1'b0;
  logic        set_err, tick_1hz, alarm_hit, pm;
  logic [3:0]  sec_ones, sec_tens;
  logic [3:0]  min_ones, min_tens;
  logic [3:0]  hour_ones, hour_tens;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_timekeeper #(
    .CLK_FREQ (4),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .mode_12h  (mode_12h),
    .set_valid (set_valid),
    .set_time  (set_time),
    .alm_valid (alm_valid),
    .alm_time  (alm_time),
    .alm_en    (alm_en),
    .set_err   (set_err),
    .tick_1hz  (tick_1hz),
    .alarm_hit (alarm_hit),
    .pm        (pm),
    .sec_ones  (sec_ones),
    .sec_tens  (sec_tens),
    .min_ones  (min_ones),
    .min_tens  (min_tens),
    .hour_ones (hour_ones),
    .hour_tens (hour_tens)
  );

  function automatic logic [31:0] disp();
    return {8'h00, hour_tens, hour_ones,
            min_tens, min_ones,
            sec_tens, sec_ones};
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_set(input logic [23:0] t);
    set_time  = t;
    set_valid = 1'b1;
    step(1);
    set_valid = 1'b0;
  endtask

  initial begin
    int ticks, last, bad, hits, first;

    step(2);
    check("rst_time", disp(), 32'h000000);
    check("rst_pulses",
          32'({set_err, tick_1hz, alarm_hit}), 0);
    check("rst_pm", 32'(pm), 0);
    mode_12h = 1'b1;
    #1;
    check("rst_12h", disp(), 32'h120000);
    check("rst_12h_pm", 32'(pm), 0);
    mode_12h = 1'b0;
    #1;

    // 1: one minute of free running
    reset = 1'b0;
    run   = 1'b1;
    ticks = 0; last = 0; bad = 0;
    for (int i = 1; i <= 240; i++) begin
      step(1);
      if (tick_1hz) begin
        ticks++;
        if (last != 0 && i - last != 4) bad++;
        last = i;
      end
    end
    check("t1_ticks", 32'(ticks), 60);
    check("t1_spacing", 32'(bad), 0);
    check("t1_last", 32'(last), 240);
    check("t1_time", disp(), 32'h000100);

    // 2: day wrap and 12h mapping
    do_set(24'h235958);
    check("t2_load", disp(), 32'h235958);
    step(4);
    check("t2_59", disp(), 32'h235959);
    check("t2_tick", 32'(tick_1hz), 1);
    step(4);
    check("t2_wrap", disp(), 32'h000000);
    mode_12h = 1'b1;
    #1;
    check("t2_12mid", disp(), 32'h120000);
    check("t2_12mid_pm", 32'(pm), 0);
    do_set(24'h130500);
    check("t2_13h", disp(), 32'h010500);
    check("t2_13h_pm", 32'(pm), 1);
    mode_12h = 1'b0;
    #1;

    // 3: rejected loads
    run = 1'b0;
    do_set(24'h240000);
    check("t3_err24", 32'(set_err), 1);
    check("t3_keep24", disp(), 32'h130500);
    step(1);
    check("t3_errclr", 32'(set_err), 0);
    do_set(24'h126000);
    check("t3_err60", 32'(set_err), 1);
    do_set(24'h12000A);
    check("t3_errA", 32'(set_err), 1);
    check("t3_keepA", disp(), 32'h130500);
    alm_time  = 16'h2400;
    alm_valid = 1'b1;
    do_set(24'h00000F);
    alm_valid = 1'b0;
    check("t3_both", 32'(set_err), 1);
    step(1);
    check("t3_once", 32'(set_err), 0);

    // 4: alarm
    run       = 1'b1;
    alm_en    = 1'b1;
    alm_time  = 16'h0730;
    alm_valid = 1'b1;
    do_set(24'h072958);
    alm_valid = 1'b0;
    check("t4_noerr", 32'(set_err), 0);
    hits = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (alarm_hit) hits++;
      if (i == 8) begin
        check("t4_hit", 32'(alarm_hit), 1);
        check("t4_hit_tk", 32'(tick_1hz), 1);
      end
    end
    check("t4_once", 32'(hits), 1);
    check("t4_time", disp(), 32'h073001);
    do_set(24'h073000);
    check("t4_setland", 32'(alarm_hit), 0);
    alm_en = 1'b0;
    do_set(24'h072958);
    hits = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (alarm_hit) hits++;
    end
    check("t4_dis", 32'(hits), 0);

    // 5: load on the terminal count
    do_set(24'h000000);
    step(3);
    do_set(24'h100000);
    check("t5_notick", 32'(tick_1hz), 0);
    check("t5_time", disp(), 32'h100000);
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (tick_1hz && first == 0) first = i;
    end
    check("t5_first", 32'(first), 4);

    // 6: hold, then async reset
    do_set(24'h050000);
    step(2);
    run = 1'b0;
    ticks = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (tick_1hz) ticks++;
    end
    check("t6_hold", 32'(ticks), 0);
    check("t6_htime", disp(), 32'h050000);
    run = 1'b1;
    first = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      if (tick_1hz && first == 0) first = i;
    end
    check("t6_resume", 32'(first), 2);
    step(1);
    reset = 1'b1;
    #1;
    check("t6_rst", disp(), 32'h000000);
    check("t6_rst_tk", 32'(tick_1hz), 0);
    reset  = 1'b0;
    alm_en = 1'b1;
    do_set(24'h235958);
    hits = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (alarm_hit) hits++;
      if (i == 8)
        check("t6_alm00", 32'(alarm_hit), 1);
    end
    check("t6_almcnt", 32'(hits), 1);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
